// File: rtl/frame_packer_if.sv
// frame_packer_if: upstream payload stream, link FIFO stream and status.
// master = stream source/sink side, slave = frame_packer.
interface frame_packer_if;
   logic        i_sync_pulse;
   logic [15:0] i_data_len;
   logic [31:0] i_data;
   logic        i_valid;
   logic        o_ready;
   logic [31:0] o_data;
   logic        o_valid;
   logic        i_ready;
   logic        o_sop;
   logic        o_eop;
   logic        o_busy;
   logic [15:0] o_frame_cnt;

   modport master (
      output i_sync_pulse, i_data_len, i_data, i_valid, i_ready,
      input  o_ready, o_data, o_valid, o_sop, o_eop, o_busy,
             o_frame_cnt
   );

   modport slave (
      input  i_sync_pulse, i_data_len, i_data, i_valid, i_ready,
      output o_ready, o_data, o_valid, o_sop, o_eop, o_busy,
             o_frame_cnt
   );
endinterface

// File: rtl/frame_packer.sv
// frame_packer: wraps the per-sync payload into header/payload/checksum/
// status frames. Ports: clk, rst_n (sync, active-low), bus (slave side).
module frame_packer #(
   parameter logic [15:0] SYNC_WORD   = 16'hA55A,
   parameter int          MASK_WORDS  = 8,
   parameter int          TIMEOUT_CYC = 1024,
   parameter logic [31:0] PAD_WORD    = 32'hDEADBEEF
) (
   input logic clk,
   input logic rst_n,
   frame_packer_if.slave bus
);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {
      IDLE, LEN, HDR0, HDR1, PAY, TRL0, TRL1
   } state_t;

   state_t        state_q, state_d;
   logic [15:0]   plen_q, plen_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [15:0]   fcnt_q, fcnt_d;
   logic [31:0]   chk_q, chk_d;
   logic [31:0]   dat_q, dat_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [1:0]    flg_q, flg_d;
   logic          pad_q, pad_d;
   logic          pend_q, pend_d;
   logic          vld_q, vld_d;
   logic          sop_q, sop_d;
   logic          eop_q, eop_d;
   logic          pass;
   logic          sync;
   logic          xfer;

   assign sync = bus.i_sync_pulse;
   assign pass = (state_q == PAY) && !pad_q;

   // A sync in PAY blocks the word offered in that cycle (it is dropped).
   assign bus.o_valid = pass ? (bus.i_valid & ~sync) : vld_q;
   assign bus.o_data  = pass ? bus.i_data : dat_q;
   assign bus.o_ready = pass & bus.i_ready & ~sync;
   assign bus.o_sop   = sop_q;
   assign bus.o_eop   = eop_q;
   assign bus.o_busy  = (state_q != IDLE);
   assign bus.o_frame_cnt = fcnt_q;

   assign xfer = bus.o_valid & bus.i_ready;

   always_comb begin
      state_d = state_q;
      plen_d  = plen_q;
      cnt_d   = cnt_q;
      fcnt_d  = fcnt_q;
      chk_d   = chk_q;
      tmo_d   = tmo_q;
      flg_d   = flg_q;
      pad_d   = pad_q;
      pend_d  = pend_q;
      dat_d   = dat_q;
      vld_d   = vld_q;
      sop_d   = sop_q;
      eop_d   = eop_q;

      unique case (state_q)
         IDLE: begin
            if (sync) state_d = LEN;
         end
         LEN: begin
            plen_d = 16'(MASK_WORDS) + bus.i_data_len;
            chk_d  = '0;
            cnt_d  = '0;
            tmo_d  = '0;
            flg_d  = '0;
            pad_d  = 1'b0;
            pend_d = 1'b0;
            if (!sync) state_d = HDR0;
         end
         HDR0, HDR1: begin
            if (sync) begin
               flg_d[1] = 1'b1;
               pend_d   = 1'b1;
               state_d  = TRL0;
            end else if (xfer) begin
               if (state_q == HDR0) state_d = HDR1;
               else if (plen_q == '0) state_d = TRL0;
               else state_d = PAY;
            end
         end
         PAY: begin
            if (xfer) begin
               chk_d = chk_q + bus.o_data;
               cnt_d = cnt_q + 16'd1;
               tmo_d = '0;
            end else if (pass && bus.i_ready && !bus.i_valid) begin
               tmo_d = tmo_q + 1'b1;
               if (tmo_d == TW'(TIMEOUT_CYC)) begin
                  pad_d    = 1'b1;
                  flg_d[0] = 1'b1;
               end
            end
            if (sync) begin
               flg_d[1] = 1'b1;
               pend_d   = 1'b1;
               state_d  = TRL0;
            end else if (xfer && cnt_d == plen_q) begin
               state_d = TRL0;
            end
         end
         TRL0: begin
            if (sync) pend_d = 1'b1;
            if (xfer) state_d = TRL1;
         end
         TRL1: begin
            if (sync) pend_d = 1'b1;
            if (xfer) begin
               fcnt_d  = fcnt_q + 16'd1;
               state_d = (pend_q | sync) ? LEN : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Registered words are loaded once on entry and held until taken.
      if (state_d != state_q || pad_d != pad_q) begin
         vld_d = 1'b0;
         dat_d = '0;
         sop_d = 1'b0;
         eop_d = 1'b0;
         unique case (state_d)
            HDR0: begin
               vld_d = 1'b1;
               sop_d = 1'b1;
               dat_d = {SYNC_WORD, fcnt_d};
            end
            HDR1: begin
               vld_d = 1'b1;
               dat_d = {16'h0000, plen_d};
            end
            PAY: begin
               vld_d = pad_d;
               dat_d = pad_d ? PAD_WORD : '0;
            end
            TRL0: begin
               vld_d = 1'b1;
               dat_d = chk_d;
            end
            TRL1: begin
               vld_d = 1'b1;
               eop_d = 1'b1;
               dat_d = {14'h0000, flg_d, fcnt_d};
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         plen_q  <= '0;
         cnt_q   <= '0;
         fcnt_q  <= '0;
         chk_q   <= '0;
         tmo_q   <= '0;
         flg_q   <= '0;
         pad_q   <= 1'b0;
         pend_q  <= 1'b0;
         dat_q   <= '0;
         vld_q   <= 1'b0;
         sop_q   <= 1'b0;
         eop_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         plen_q  <= plen_d;
         cnt_q   <= cnt_d;
         fcnt_q  <= fcnt_d;
         chk_q   <= chk_d;
         tmo_q   <= tmo_d;
         flg_q   <= flg_d;
         pad_q   <= pad_d;
         pend_q  <= pend_d;
         dat_q   <= dat_d;
         vld_q   <= vld_d;
         sop_q   <= sop_d;
         eop_q   <= eop_d;
      end
   end
endmodule

// File: tb/tb_frame_packer.sv
// tb_frame_packer: directed frames with a scoreboard queue of expected
// link words, popped by a monitor on every link transfer.
module tb_frame_packer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   frame_packer_if bus();

   frame_packer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] d;
      logic        sop;
      logic        eop;
      logic        regw;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int errors = 0;
   bit bp = 0;
   logic [15:0] fc = 16'h0;

   task automatic tick();
      @(posedge clk);
      #1;
      if (bp) bus.i_ready = ~bus.i_ready;
   endtask

   task automatic push(input logic [31:0] d, input logic s,
                       input logic e, input logic r);
      exp_t x;
      x.d = d; x.sop = s; x.eop = e; x.regw = r;
      q.push_back(x);
   endtask

   task automatic push_hdr(input logic [15:0] plen);
      push({16'hA55A, fc}, 1'b1, 1'b0, 1'b1);
      push({16'h0000, plen}, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic push_trl(input logic [31:0] chk, input logic [15:0] flg);
      push(chk, 1'b0, 1'b0, 1'b1);
      push({flg, fc}, 1'b0, 1'b1, 1'b1);
      fc = fc + 16'd1;
   endtask

   task automatic do_sync();
      bus.i_sync_pulse = 1'b1;
      tick();
      bus.i_sync_pulse = 1'b0;
   endtask

   task automatic start_frame(input logic [15:0] len, input logic [15:0] plen);
      bus.i_data_len = len;
      push_hdr(plen);
      do_sync();
   endtask

   task automatic send_word(input logic [31:0] d);
      int n;
      logic acc;
      n = 0;
      acc = 1'b0;
      push(d, 1'b0, 1'b0, 1'b0);
      bus.i_valid = 1'b1;
      bus.i_data = d;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = bus.o_ready;
         tick();
         n++;
      end
      if (!acc) begin
         checks++; errors++;
         $display("FAIL accept: word %h not taken, want taken", d);
      end
      bus.i_valid = 1'b0;
      bus.i_data = '0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      logic idle;
      n = 0;
      idle = 1'b0;
      while (!idle && n < 3000) begin
         @(negedge clk);
         idle = !bus.o_busy;
         if (!idle) tick();
         n++;
      end
      checks++;
      if (!idle) begin
         errors++;
         $display("FAIL %s idle: busy=1, want 0", name);
      end
      if (idle) tick();
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL %s drained: %0d words left, want 0", name, q.size());
         q.delete();
      end
   endtask

   task automatic chk_quiet(input string name);
      checks++;
      if (bus.o_valid || bus.o_ready || bus.o_sop || bus.o_eop ||
          bus.o_busy || bus.o_data != 0 || bus.o_frame_cnt != 0) begin
         errors++;
         $display("FAIL %s: v%0b r%0b s%0b e%0b b%0b d=%h fc=%h, want all 0",
                  name, bus.o_valid, bus.o_ready, bus.o_sop, bus.o_eop,
                  bus.o_busy, bus.o_data, bus.o_frame_cnt);
      end
   endtask

   task automatic chk_fc(input string name, input logic [15:0] want);
      checks++;
      if (bus.o_frame_cnt != want) begin
         errors++;
         $display("FAIL %s: frame_cnt=%h, want %h", name, bus.o_frame_cnt, want);
      end
   endtask

   task automatic monitor();
      exp_t e;
      logic [31:0] held;
      bit hold;
      hold = 0;
      held = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hold = 0;
            continue;
         end
         if (hold) begin
            checks++;
            if (!(bus.o_valid && bus.o_data == held)) begin
               errors++;
               $display("FAIL hold: v%0b d=%h, want v1 d=%h",
                        bus.o_valid, bus.o_data, held);
            end
         end
         hold = 0;
         if (bus.o_valid && bus.i_ready) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL extra: got %h, want no word", bus.o_data);
            end else begin
               e = q.pop_front();
               if (bus.o_data != e.d || bus.o_sop != e.sop ||
                   bus.o_eop != e.eop) begin
                  errors++;
                  $display("FAIL word: got %h s%0b e%0b, want %h s%0b e%0b",
                           bus.o_data, bus.o_sop, bus.o_eop,
                           e.d, e.sop, e.eop);
               end
            end
         end else if (bus.o_valid && q.size() > 0 && q[0].regw) begin
            hold = 1;
            held = bus.o_data;
         end
      end
   endtask

   initial begin
      bus.i_sync_pulse = 1'b0;
      bus.i_data_len = '0;
      bus.i_data = '0;
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b1;
      fork
         monitor();
      join_none

      repeat (3) tick();
      chk_quiet("reset");
      rst_n = 1'b1;
      tick();
      chk_quiet("idle");

      // normal frame
      start_frame(16'd4, 16'd12);
      for (int i = 1; i <= 12; i++) send_word(32'(i));
      push_trl(32'h0000004E, 16'h0000);
      wait_idle("normal");
      chk_fc("normal_cnt", 16'd1);

      // backpressure
      bp = 1;
      start_frame(16'd4, 16'd12);
      for (int i = 1; i <= 12; i++) send_word(32'(i));
      push_trl(32'h0000004E, 16'h0000);
      wait_idle("bp");
      bp = 0;
      bus.i_ready = 1'b1;
      chk_fc("bp_cnt", 16'd2);

      // timeout: 9 of 10 words, then a pad word
      start_frame(16'd2, 16'd10);
      for (int i = 1; i <= 9; i++) send_word(32'(i));
      push(32'hDEADBEEF, 1'b0, 1'b0, 1'b1);
      push_trl(32'hDEADBF1C, 16'h0001);
      wait_idle("timeout");

      // abort after 3 words, pending sync starts the next frame
      start_frame(16'd4, 16'd12);
      for (int i = 1; i <= 3; i++) send_word(32'(i));
      push_trl(32'h00000006, 16'h0002);
      push_hdr(16'd8);
      bus.i_data_len = 16'd0;
      do_sync();
      for (int i = 1; i <= 8; i++) send_word(32'(i));
      push_trl(32'h00000024, 16'h0000);
      wait_idle("abort");
      chk_fc("abort_cnt", 16'd5);

      // frame counter wrap
      force dut.fcnt_q = 16'hFFFF;
      tick();
      release dut.fcnt_q;
      fc = 16'hFFFF;
      start_frame(16'd0, 16'd8);
      for (int i = 1; i <= 8; i++) send_word(32'(i));
      push_trl(32'h00000024, 16'h0000);
      wait_idle("wrap");
      chk_fc("wrap_cnt", 16'd0);

      // plen wraps to zero: no payload
      start_frame(16'hFFF8, 16'd0);
      push_trl(32'h00000000, 16'h0000);
      wait_idle("zero");

      // reset mid-payload
      start_frame(16'd4, 16'd12);
      send_word(32'h11);
      send_word(32'h22);
      rst_n = 1'b0;
      tick();
      chk_quiet("midrst");
      rst_n = 1'b1;
      fc = 16'h0;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL midrst_q: %0d words left, want 0", q.size());
         q.delete();
      end
      tick();
      start_frame(16'd4, 16'd12);
      for (int i = 1; i <= 12; i++) send_word(32'(i));
      push_trl(32'h0000004E, 16'h0000);
      wait_idle("postrst");
      chk_fc("postrst_cnt", 16'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
